// File: rtl/if_id_stage.sv
// IF/ID pipeline register for the 16-bit 5-stage pipeline.
// Captures PC+1 and the instruction from fetch and detects load-use hazards
// against the LW in EX. Drives the global stall and tracks a sticky halt.
module if_id_stage #(
    parameter logic [15:0] NOP_INSTR = 16'h0000,
    parameter logic [3:0]  HLT_OP    = 4'hF,
    parameter logic [3:0]  LW_OP     = 4'h8,
    parameter logic [3:0]  SW_OP     = 4'h9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_inc_if,
    input  logic [15:0] instr_if,
    input  logic        flush,
    input  logic        ex_memrd,
    input  logic [3:0]  ex_rd,
    output logic [15:0] pc_inc_id,
    output logic [15:0] instr_id,
    output logic        valid_id,
    output logic [3:0]  rs_id,
    output logic [3:0]  rt_id,
    output logic        stall,
    output logic        bubble_ex,
    output logic        halted
);

    // RET implicitly reads the link register R15.
    localparam logic [3:0] RET_OP  = 4'hE;
    localparam logic [3:0] LINK_RG = 4'hF;

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e     state_q;
    logic [3:0] opcode;
    logic       ret_op;
    logic       uses_rs;
    logic       uses_rt;
    logic       hazard;

    // Decode source registers and detect a load-use dependency on the EX LW.
    always_comb begin
        opcode  = instr_id[15:12];
        ret_op  = (opcode == RET_OP);
        rs_id   = ret_op ? LINK_RG : instr_id[7:4];
        // SW reads its store-data register from the rd field.
        rt_id   = (opcode == SW_OP) ? instr_id[11:8] : instr_id[3:0];
        uses_rs = ~opcode[3] | (opcode == LW_OP) | (opcode == SW_OP) | ret_op;
        uses_rt = ~opcode[3] | (opcode == SW_OP);
        hazard  = valid_id & ex_memrd & (ex_rd != 4'h0) &
                  ((uses_rs & (ex_rd == rs_id)) | (uses_rt & (ex_rd == rt_id)));
    end

    // Stall/bubble requests; forced low while reset is asserted.
    always_comb begin
        stall     = 1'b0;
        bubble_ex = 1'b0;
        if (!rst) begin
            if (state_q == StHalt) begin
                stall     = 1'b1;
                bubble_ex = 1'b1;
            end else begin
                // A resolved control transfer discards ID, so it wins over a hazard.
                stall     = hazard & ~flush;
                bubble_ex = hazard | flush;
            end
        end
    end

    // Run/halt FSM; halted is registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            halted  <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (valid_id && (opcode == HLT_OP) && !flush) begin
                        state_q <= StHalt;
                        halted  <= 1'b1;
                    end
                end
                StHalt: begin
                    state_q <= StHalt;
                    halted  <= 1'b1;
                end
                default: begin
                    state_q <= StRun;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID register: flush injects a bubble, hazard holds, halt freezes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_inc_id <= 16'h0000;
            instr_id  <= NOP_INSTR;
            valid_id  <= 1'b0;
        end else if (state_q == StRun) begin
            if (flush) begin
                pc_inc_id <= pc_inc_if;
                instr_id  <= NOP_INSTR;
                valid_id  <= 1'b0;
            end else if (!hazard) begin
                pc_inc_id <= pc_inc_if;
                instr_id  <= instr_if;
                valid_id  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios plus randomized traffic checked
// against a register-read-mask reference model.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc_inc_if = 16'h0;
    logic [15:0] instr_if = 16'h0;
    logic        flush = 1'b0;
    logic        ex_memrd = 1'b0;
    logic [3:0]  ex_rd = 4'h0;
    logic [15:0] pc_inc_id;
    logic [15:0] instr_id;
    logic        valid_id;
    logic [3:0]  rs_id;
    logic [3:0]  rt_id;
    logic        stall;
    logic        bubble_ex;
    logic        halted;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic        m_valid;
    logic        m_halt;

    if_id_stage dut (
        .clk       (clk),
        .rst       (rst),
        .pc_inc_if (pc_inc_if),
        .instr_if  (instr_if),
        .flush     (flush),
        .ex_memrd  (ex_memrd),
        .ex_rd     (ex_rd),
        .pc_inc_id (pc_inc_id),
        .instr_id  (instr_id),
        .valid_id  (valid_id),
        .rs_id     (rs_id),
        .rt_id     (rt_id),
        .stall     (stall),
        .bubble_ex (bubble_ex),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Set of registers an instruction reads, one bit per register.
    function automatic logic [15:0] read_set(input logic [15:0] ins);
        logic [15:0] s;
        int op;
        s  = 16'h0;
        op = int'(ins[15:12]);
        if (op < 8) begin
            s[ins[7:4]] = 1'b1;
            s[ins[3:0]] = 1'b1;
        end else if (op == 8) begin
            s[ins[7:4]] = 1'b1;
        end else if (op == 9) begin
            s[ins[7:4]]  = 1'b1;
            s[ins[11:8]] = 1'b1;
        end else if (op == 14) begin
            s[15] = 1'b1;
        end
        return s;
    endfunction

    function automatic logic model_hazard();
        logic [15:0] s;
        s = read_set(m_instr);
        return m_valid && ex_memrd && (ex_rd != 0) && s[ex_rd];
    endfunction

    task automatic model_reset();
        m_pc    = 16'h0;
        m_instr = 16'h0000;
        m_valid = 1'b0;
        m_halt  = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        logic [3:0] e_rs;
        logic [3:0] e_rt;
        e_rs = (m_instr[15:12] == 4'hE) ? 4'hF : m_instr[7:4];
        e_rt = (m_instr[15:12] == 4'h9) ? m_instr[11:8] : m_instr[3:0];
        chk({tag, ".pc_inc_id"}, pc_inc_id, m_pc);
        chk({tag, ".instr_id"}, instr_id, m_instr);
        chk({tag, ".valid_id"}, 16'(valid_id), 16'(m_valid));
        chk({tag, ".rs_id"}, 16'(rs_id), 16'(e_rs));
        chk({tag, ".rt_id"}, 16'(rt_id), 16'(e_rt));
        chk({tag, ".halted"}, 16'(halted), 16'(m_halt));
    endtask

    // Apply rst asynchronously, away from any clock edge.
    task automatic do_reset(input string tag);
        rst   = 1'b1;
        flush = 1'b1;
        #1;
        model_reset();
        check_regs(tag);
        chk({tag, ".stall"}, 16'(stall), 16'h0);
        chk({tag, ".bubble_ex"}, 16'(bubble_ex), 16'h0);
        rst   = 1'b0;
        flush = 1'b0;
    endtask

    // One clock cycle: drive, check combinational outputs, clock, check registers.
    task automatic cycle(input string tag, input logic [15:0] pc, input logic [15:0] ins,
                         input logic fl, input logic mr, input logic [3:0] rd);
        logic hz;
        logic e_stall;
        logic e_bub;
        pc_inc_if = pc;
        instr_if  = ins;
        flush     = fl;
        ex_memrd  = mr;
        ex_rd     = rd;
        #1;
        hz      = model_hazard();
        e_stall = m_halt ? 1'b1 : (hz && !fl);
        e_bub   = m_halt ? 1'b1 : (hz || fl);
        chk({tag, ".stall"}, 16'(stall), 16'(e_stall));
        chk({tag, ".bubble_ex"}, 16'(bubble_ex), 16'(e_bub));
        @(posedge clk);
        if (!m_halt) begin
            if (m_valid && m_instr[15:12] == 4'hF && !fl) m_halt = 1'b1;
            if (fl) begin
                m_pc    = pc;
                m_instr = 16'h0000;
                m_valid = 1'b0;
            end else if (!hz) begin
                m_pc    = pc;
                m_instr = ins;
                m_valid = 1'b1;
            end
        end
        #1;
        check_regs(tag);
    endtask

    initial begin
        logic [15:0] ins;
        logic [3:0]  rd;
        int          halt_cnt;
        rst = 1'b1;
        #1;
        do_reset("reset");
        @(posedge clk);
        #1;

        // Stream two instructions
        cycle("stream0", 16'd1, 16'h1123, 1'b0, 1'b0, 4'h0);
        cycle("stream1", 16'd2, 16'h2456, 1'b0, 1'b0, 4'h0);

        // Load-use on rs, then clears once EX holds the bubble
        cycle("lu_load", 16'd3, 16'h0321, 1'b0, 1'b0, 4'h0);
        cycle("lu_hz", 16'd4, 16'h3777, 1'b0, 1'b1, 4'h2);
        cycle("lu_clear", 16'd4, 16'h0321, 1'b0, 1'b0, 4'h0);
        cycle("lu_r0", 16'd5, 16'h3777, 1'b0, 1'b1, 4'h0);

        // SW reads rs and the rd field
        cycle("sw_load", 16'd6, 16'h9512, 1'b0, 1'b0, 4'h0);
        cycle("sw_rd5", 16'd7, 16'h9512, 1'b0, 1'b1, 4'h5);
        cycle("sw_rt2", 16'd7, 16'h9512, 1'b0, 1'b1, 4'h2);
        cycle("sw_rs1", 16'd8, 16'h9512, 1'b0, 1'b1, 4'h1);
        cycle("sw_r7", 16'd8, 16'h9512, 1'b0, 1'b1, 4'h7);

        // RET reads R15 only
        cycle("ret_load", 16'd9, 16'hE123, 1'b0, 1'b0, 4'h0);
        cycle("ret_hz", 16'd10, 16'h0000, 1'b0, 1'b1, 4'hF);

        // Flush beats hazard
        cycle("fl_load", 16'd11, 16'h0321, 1'b0, 1'b0, 4'h0);
        cycle("fl_hz", 16'd12, 16'h4abc, 1'b1, 1'b1, 4'h2);

        // Halt: sticky, flush ignored, cleared only by reset
        cycle("h_load", 16'd13, 16'hF000, 1'b0, 1'b0, 4'h0);
        cycle("h_enter", 16'd14, 16'h1111, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 10; i++)
            cycle("h_hold", 16'(20 + i), 16'h2222, (i == 4), 1'b0, 4'h0);
        do_reset("h_rst");

        // HLT discarded by a flush
        cycle("hf_load", 16'd30, 16'hF000, 1'b0, 1'b0, 4'h0);
        cycle("hf_flush", 16'd31, 16'h1234, 1'b1, 1'b0, 4'h0);
        cycle("hf_after", 16'd32, 16'h1234, 1'b0, 1'b0, 4'h0);

        // Randomized traffic
        halt_cnt = 0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 39) == 0) ins = {4'hF, 12'($urandom)};
            else ins = {4'($urandom_range(0, 14)), 12'($urandom)};
            if ($urandom_range(0, 1) == 1) rd = ($urandom_range(0, 1) == 1) ? m_instr[7:4] : m_instr[11:8];
            else rd = 4'($urandom);
            cycle("rand", 16'($urandom), ins, ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 2) == 0), rd);
            halt_cnt = m_halt ? halt_cnt + 1 : 0;
            if (halt_cnt > 4 || $urandom_range(0, 79) == 0) do_reset("rand_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
